// File: rtl/condicionador_entradas.sv
// Input conditioning for the door-system FSM: per-bit two-flop synchroniser,
// counter-based debounce, and one-cycle rise/fall pulses on accepted changes.
module condicionador_entradas #(
  parameter int unsigned N_IN       = 5,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_IN-1:0] entrada,
  output logic [N_IN-1:0] saida,
  output logic [N_IN-1:0] subida,
  output logic [N_IN-1:0] descida,
  output logic            estavel
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [N_IN-1:0]  s1;
  logic [N_IN-1:0]  s2;
  logic [CNT_W-1:0] cnt [N_IN];

  // Two-flop synchroniser, no logic between the stages.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= entrada;
      s2 <= s1;
    end
  end

  // Per-bit debounce: accept s2 once it has differed from saida for DEB_CYCLES edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saida   <= '0;
      subida  <= '0;
      descida <= '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      subida  <= '0;
      descida <= '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (s2[i] == saida[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          saida[i]   <= s2[i];
          subida[i]  <= s2[i];
          descida[i] <= ~s2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Settled when every bit matches its synchronised input with no count in progress.
  always_comb begin
    estavel = 1'b1;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if ((s2[i] != saida[i]) || (cnt[i] != '0)) begin
        estavel = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_condicionador_entradas.sv
// Bench for condicionador_entradas: directed scenarios plus randomised inputs,
// checked every cycle against a history-based reference model.
module tb_condicionador_entradas;

  localparam int unsigned N   = 5;
  localparam int unsigned DEB = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] entrada;
  logic [N-1:0] saida;
  logic [N-1:0] subida;
  logic [N-1:0] descida;
  logic         estavel;

  int checks   = 0;
  int failures = 0;

  condicionador_entradas #(
    .N_IN       (N),
    .DEB_CYCLES (DEB),
    .CNT_W      (3)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .entrada (entrada),
    .saida   (saida),
    .subida  (subida),
    .descida (descida),
    .estavel (estavel)
  );

  always #25 clock = ~clock;

  // Reference model: raw input samples per edge since reset, and the value
  // the synchronised input held before each edge (input seen two edges earlier).
  logic [N-1:0] hist  [$];
  logic [N-1:0] s2seq [$];
  logic [N-1:0] m_saida;
  logic [N-1:0] m_sub;
  logic [N-1:0] m_des;
  logic         m_est;

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    s2seq.delete();
    m_saida = '0;
    m_sub   = '0;
    m_des   = '0;
    m_est   = 1'b1;
  endtask

  task automatic model_edge();
    logic [N-1:0] s2_before;
    logic [N-1:0] s2_after;
    bit           accept;
    int           last;
    s2_before = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    s2seq.push_back(s2_before);
    hist.push_back(entrada);
    m_sub = '0;
    m_des = '0;
    last  = s2seq.size() - 1;
    for (int i = 0; i < N; i++) begin
      // A change is accepted when the last DEB samples all disagree with saida.
      accept = (s2seq.size() >= DEB);
      for (int k = 0; k < DEB; k++) begin
        if (accept && (s2seq[last-k][i] == m_saida[i])) accept = 1'b0;
      end
      if (accept) begin
        m_saida[i] = s2_before[i];
        m_sub[i]   = s2_before[i];
        m_des[i]   = ~s2_before[i];
      end
    end
    s2_after = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    m_est = 1'b1;
    for (int i = 0; i < N; i++) begin
      // Pending if the synchronised value differs now, or the latest sample
      // started an unfinished run of disagreement.
      if (s2_after[i] != m_saida[i]) m_est = 1'b0;
      if (s2seq[last][i] != m_saida[i]) m_est = 1'b0;
    end
    while (hist.size() > 4) void'(hist.pop_front());
    while (s2seq.size() > DEB + 2) void'(s2seq.pop_front());
  endtask

  task automatic compare_all();
    confere("saida",   32'(saida),   32'(m_saida));
    confere("subida",  32'(subida),  32'(m_sub));
    confere("descida", 32'(descida), 32'(m_des));
    confere("estavel", 32'(estavel), 32'(m_est));
    confere("pulse_excl", 32'(subida & descida), 32'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  // Called at a falling edge: asynchronous reset must clear outputs at once.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    #10;
    reset = 1'b0;
  endtask

  int pulses4;
  int hold [N];

  initial begin
    entrada = 5'b10110;
    reset   = 1'b1;
    model_reset();
    #5;
    compare_all();
    @(negedge clock);
    compare_all();
    #10;
    reset   = 1'b0;
    entrada = 5'b00000;

    // Clean step
    repeat (8) tick();
    entrada = 5'b10110;
    repeat (8) tick();

    // Glitches on bit 1: three cycles rejected, four accepted
    entrada = 5'b10100;
    repeat (8) tick();
    entrada = 5'b10110;
    repeat (3) tick();
    entrada = 5'b10100;
    repeat (8) tick();
    entrada = 5'b10110;
    repeat (4) tick();
    entrada = 5'b10100;
    repeat (8) tick();

    // Release: several bits fall and one rises on the same edge
    entrada = 5'b10110;
    repeat (8) tick();
    entrada = 5'b00011;
    repeat (8) tick();

    // Reset mid-debounce, input held across release
    entrada = 5'b11100;
    repeat (2) tick();
    do_reset();
    repeat (8) tick();

    // Bounce on bit 4, then hold high: exactly one rising pulse
    entrada = 5'b00000;
    repeat (8) tick();
    pulses4 = 0;
    for (int t = 0; t < 10; t++) begin
      entrada[4] = ~entrada[4];
      tick();
      if (subida[4]) pulses4++;
    end
    entrada[4] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (subida[4]) pulses4++;
    end
    confere("bounce_pulses", 32'(pulses4), 32'd1);

    // Randomised per-bit hold times, with occasional resets
    for (int b = 0; b < N; b++) hold[b] = 0;
    for (int t = 0; t < 1500; t++) begin
      for (int b = 0; b < N; b++) begin
        if (hold[b] == 0) begin
          entrada[b] = 1'($urandom_range(0, 1));
          hold[b]    = $urandom_range(1, 7);
        end
        hold[b]--;
      end
      if ($urandom_range(0, 249) == 0) do_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
